// File: rtl/ser2par.sv
`timescale 1ns/1ps
// ser2par: serial-to-parallel deserializer.
// Collects a WIDTH-bit word sent LSB-first, one bit per din_vld cycle. Frames
// start on a qualified sof. Each completed word is presented in a holding
// register under a valid/ready handshake. Sticky flags report dropped words
// (overflow) and frames cut short by a new sof (frame_err).
module ser2par #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    input  logic             sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             busy,
    output logic             overflow,
    output logic             frame_err,
    input  logic             clr_err
);

    // The bit counter must hold values 0..WIDTH-1.
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   shreg_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic [WIDTH-1:0]   dout_r;
    logic               dout_vld_r;
    logic               overflow_r;
    logic               frame_err_r;

    logic [WIDTH-1:0]   shift_s;
    logic               complete_s;
    logic               drain_s;
    logic               load_s;
    logic               ovf_set_s;
    logic               ferr_set_s;

    // Decode the per-cycle events: shifted word, completion, drain, load, flag sets.
    always_comb begin
        shift_s    = {din, shreg_r[WIDTH-1:1]};
        complete_s = 1'b0;
        ferr_set_s = 1'b0;
        if ((state_r == SHIFT) && din_vld) begin
            // A sof mid-frame restarts the frame rather than completing it.
            if (sof) begin
                ferr_set_s = 1'b1;
            end else if (cnt_r == LAST_C) begin
                complete_s = 1'b1;
            end else begin
                complete_s = 1'b0;
            end
        end else begin
            complete_s = 1'b0;
            ferr_set_s = 1'b0;
        end
        drain_s = dout_vld_r & dout_rdy;
        if (complete_s) begin
            // Load when empty or when the held word leaves this same cycle.
            load_s    = ~dout_vld_r | dout_rdy;
            ovf_set_s = dout_vld_r & ~dout_rdy;
        end else begin
            load_s    = 1'b0;
            ovf_set_s = 1'b0;
        end
    end

    // Frame FSM: shift register, bit counter, state and registered busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            shreg_r <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (din_vld && sof) begin
                        shreg_r <= shift_s;
                        cnt_r   <= ONE_C;
                        state_r <= SHIFT;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!din_vld) begin
                        state_r <= SHIFT;
                        busy_r  <= 1'b1;
                    end else if (sof) begin
                        // Restart: this din becomes bit 0 of a fresh frame.
                        shreg_r <= shift_s;
                        cnt_r   <= ONE_C;
                        state_r <= SHIFT;
                        busy_r  <= 1'b1;
                    end else if (cnt_r == LAST_C) begin
                        shreg_r <= shift_s;
                        cnt_r   <= '0;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        shreg_r <= shift_s;
                        cnt_r   <= cnt_r + ONE_C;
                        state_r <= SHIFT;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    shreg_r <= '0;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register and its valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r     <= '0;
            dout_vld_r <= 1'b0;
        end else if (load_s) begin
            dout_r     <= shift_s;
            dout_vld_r <= 1'b1;
        end else if (drain_s) begin
            dout_vld_r <= 1'b0;
        end else begin
            dout_vld_r <= dout_vld_r;
        end
    end

    // Sticky error flags; a set event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (ferr_set_s) begin
                frame_err_r <= 1'b1;
            end else if (clr_err) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end
    end

    assign dout      = dout_r;
    assign dout_vld  = dout_vld_r;
    assign busy      = busy_r;
    assign overflow  = overflow_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ser2par.sv
`timescale 1ns/1ps
// Directed testbench for ser2par (WIDTH=8).
module tb_ser2par;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_vld;
    logic       sof;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_rdy;
    logic       busy;
    logic       overflow;
    logic       frame_err;
    logic       clr_err;

    int n_chk  = 0;
    int n_fail = 0;

    ser2par #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_vld   (din_vld),
        .sof       (sof),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .busy      (busy),
        .overflow  (overflow),
        .frame_err (frame_err),
        .clr_err   (clr_err)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, pass the rising edge, settle 1 ns, release strobes.
    task automatic step(input logic d, input logic v, input logic s);
        din     = d;
        din_vld = v;
        sof     = s;
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        sof     = 1'b0;
        clr_err = 1'b0;
    endtask

    // Send a full word LSB-first; gaps[i] inserts an idle cycle after bit i.
    task automatic send_word(input logic [7:0] w, input logic [7:0] gaps);
        for (int i = 0; i < 8; i++) begin
            step(w[i], 1'b1, (i == 0));
            if (gaps[i] && i != 7) step(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] w;
        rst = 1'b1; din = 1'b0; din_vld = 1'b0; sof = 1'b0;
        dout_rdy = 1'b1; clr_err = 1'b0;
        #1;

        // Reset with random serial activity
        for (int i = 0; i < 2; i++) step(1'($urandom), 1'($urandom), 1'($urandom));
        chk("rst_dout", dout, 8'h00);
        chk("rst_vld", dout_vld, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // Single word 0xA5
        w = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            step(w[i], 1'b1, (i == 0));
            if (i == 3) chk("a5_busy_mid", busy, 1'b1);
            if (i < 7) chk("a5_vld_early", dout_vld, 1'b0);
        end
        chk("a5_dout", dout, 8'hA5);
        chk("a5_vld", dout_vld, 1'b1);
        chk("a5_busy", busy, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("a5_vld_drop", dout_vld, 1'b0);

        // Gapped 0x3C followed immediately by 0xC3
        send_word(8'h3C, 8'b0010_0100);
        chk("3c_dout", dout, 8'h3C);
        chk("3c_vld", dout_vld, 1'b1);
        send_word(8'hC3, 8'h00);
        chk("c3_dout", dout, 8'hC3);
        chk("c3_vld", dout_vld, 1'b1);
        chk("c3_ovf", overflow, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Overflow: hold 0x11, drop 0x22
        dout_rdy = 1'b0;
        send_word(8'h11, 8'h00);
        chk("ovf_dout1", dout, 8'h11);
        chk("ovf_ovf0", overflow, 1'b0);
        send_word(8'h22, 8'h00);
        chk("ovf_dout2", dout, 8'h11);
        chk("ovf_vld", dout_vld, 1'b1);
        chk("ovf_set", overflow, 1'b1);
        dout_rdy = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("ovf_drain_vld", dout_vld, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);
        clr_err = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("ovf_clr", overflow, 1'b0);

        // Same-cycle drain and load: 0x11 held, ready on 0x55 last bit
        dout_rdy = 1'b0;
        send_word(8'h11, 8'h00);
        chk("dl_held", dout, 8'h11);
        w = 8'h55;
        for (int i = 0; i < 8; i++) begin
            dout_rdy = (i == 7);
            step(w[i], 1'b1, (i == 0));
        end
        dout_rdy = 1'b0;
        chk("dl_dout", dout, 8'h55);
        chk("dl_vld", dout_vld, 1'b1);
        chk("dl_ovf", overflow, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("dl_stable", dout, 8'h55);
        dout_rdy = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("dl_drain", dout_vld, 1'b0);

        // Frame restart: 3 bits then a full 0x81 frame
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("fr_busy", busy, 1'b1);
        chk("fr_ferr0", frame_err, 1'b0);
        send_word(8'h81, 8'h00);
        chk("fr_dout", dout, 8'h81);
        chk("fr_vld", dout_vld, 1'b1);
        chk("fr_ferr", frame_err, 1'b1);
        clr_err = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("fr_clr", frame_err, 1'b0);

        // Clear and set in the same cycle: set wins
        step(1'b0, 1'b1, 1'b1);
        clr_err = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        chk("fr_set_wins", frame_err, 1'b1);
        clr_err = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("fr_clr2", frame_err, 1'b0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Reset mid-frame with 0x7E held
        dout_rdy = 1'b0;
        send_word(8'h7E, 8'h00);
        chk("rm_held", dout, 8'h7E);
        w = 8'hFF;
        for (int i = 0; i < 4; i++) step(w[i], 1'b1, (i == 0));
        chk("rm_busy", busy, 1'b1);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        chk("rm_dout", dout, 8'h00);
        chk("rm_vld", dout_vld, 1'b0);
        chk("rm_busy0", busy, 1'b0);
        chk("rm_ovf", overflow, 1'b0);
        chk("rm_ferr", frame_err, 1'b0);
        rst = 1'b0;
        dout_rdy = 1'b1;
        send_word(8'h96, 8'h00);
        chk("rm_next_dout", dout, 8'h96);
        chk("rm_next_vld", dout_vld, 1'b1);
        chk("rm_next_ferr", frame_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
